// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared constants and types for the RISC-V front end.
//             NOP_INSTRUCTION    - canonical NOP (ADDI x0,x0,0).
//             EBREAK_INSTRUCTION - EBREAK encoding that halts fetch when the
//                                  RISCV_IF_EBREAK_HALT_EN macro is defined.
//             if_state_t         - fetch-stage state (RUN, HALT).
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [31:0] NOP_INSTRUCTION    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTRUCTION = 32'h0010_0073;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } if_state_t;

endpackage
`default_nettype wire

// File: rtl/riscv_if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_if_stage_if
//  Purpose  : Bundles the fetch stage's control, instruction-memory and
//             decode-facing signals.
//  Modports : master - the fetch stage (drives iMemRead, PC, if_*, halted,
//                      fetch_count; samples stall, redirect_*, instruction).
//             slave  - the surrounding pipeline / memory (opposite directions).
//  Revision : 1.0 - initial release
// ============================================================================
interface riscv_if_stage_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iMemRead;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, instruction,
    output iMemRead, PC, if_valid, if_pc, if_instruction, halted, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, instruction,
    input  iMemRead, PC, if_valid, if_pc, if_instruction, halted, fetch_count
  );

endinterface
`default_nettype wire

// File: rtl/riscv_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pc_gen
//  Purpose  : Program counter register with next-PC mux and incrementer.
//  Ports    : clk        - system clock
//             rst        - asynchronous active-low reset (loads INITIAL_PC)
//             i_load     - take i_load_pc as the next PC (redirect)
//             i_load_pc  - redirect target
//             i_advance  - step the PC by PC_STEP (a fetch was issued)
//             o_pc       - current fetch address
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_pc_gen #(
  parameter logic [31:0] INITIAL_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP    = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_load,
  input  wire logic [31:0] i_load_pc,
  input  wire logic        i_advance,
  output logic      [31:0] o_pc
);

  localparam logic [31:0] c_pc_step = 32'(PC_STEP);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // Load has priority over increment; with neither the PC holds.
  always_comb begin
    w_pc_next = r_pc;
    if (i_load) begin
      w_pc_next = i_load_pc;
    end else if (i_advance) begin
      w_pc_next = r_pc + c_pc_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= INITIAL_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/riscv_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_if_stage
//  Purpose  : Instruction-fetch stage. Issues at most one fetch per cycle to a
//             synchronous-read instruction memory and presents the returned
//             word to decode with its PC and a valid flag. Handles stall
//             hold, redirect squash and (optionally) EBREAK halt, and counts
//             words accepted by decode.
//  Ports    : clk  - system clock
//             rst  - asynchronous active-low reset
//             bus  - riscv_if_stage_if.master (stall, redirect_valid,
//                    redirect_pc, instruction in; iMemRead, PC, if_valid,
//                    if_pc, if_instruction, halted, fetch_count out)
//  Config   : RISCV_IF_EBREAK_HALT_EN - when defined, accepting EBREAK moves
//             the stage to HALT; otherwise EBREAK is an ordinary word and
//             halted is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP    = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  riscv_if_stage_if.master  bus
);

  if_state_t   r_state;
  if_state_t   w_state_next;
  logic        r_fv;
  logic        w_fv_next;
  logic [31:0] r_if_pc;
  logic [31:0] r_fetch_count;
  logic        w_run;
  logic        w_mem_read;
  logic        w_accept;
  logic        w_halt_trig;
  logic [31:0] w_pc;

  // A word is consumed by decode whenever it is valid and not held.
  assign w_accept = r_fv && !bus.stall;

`ifdef RISCV_IF_EBREAK_HALT_EN
  // r_fv guarantees the memory output is the word presented to decode.
  assign w_halt_trig = w_accept && (bus.instruction == EBREAK_INSTRUCTION);
`else
  assign w_halt_trig = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The read enable is gated by rst so no read is requested while the stage
  // is held in reset.
  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    w_mem_read   = 1'b0;
    case (r_state)
      RUN: begin
        w_run      = 1'b1;
        w_mem_read = rst && !bus.stall && !bus.redirect_valid;
        if (w_halt_trig) begin
          w_state_next = HALT;
        end
      end
      HALT: begin
        w_state_next = HALT;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC generation. An EBREAK accept drops any concurrent redirect and keeps
  // the PC at the address following the EBREAK, so the halted PC points at
  // the next instruction rather than one beyond it.
  // --------------------------------------------------------------------------
  riscv_pc_gen #(
    .INITIAL_PC (INITIAL_PC),
    .PC_STEP    (PC_STEP)
  ) u_pc_gen (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_run && bus.redirect_valid && !w_halt_trig),
    .i_load_pc (bus.redirect_pc),
    .i_advance (w_mem_read && !w_halt_trig),
    .o_pc      (w_pc)
  );

  // --------------------------------------------------------------------------
  // Fetch-valid flag: cleared by halt or redirect (squashing the fetch in
  // flight), held under stall, otherwise follows the read issued this cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fv_next = r_fv;
    if (!w_run || w_halt_trig || bus.redirect_valid) begin
      w_fv_next = 1'b0;
    end else if (!bus.stall) begin
      w_fv_next = w_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fv          <= 1'b0;
      r_if_pc       <= INITIAL_PC;
      r_fetch_count <= 32'h0;
    end else begin
      r_fv <= w_fv_next;
      if (w_mem_read) begin
        r_if_pc <= w_pc;
      end
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.iMemRead       = w_mem_read;
  assign bus.PC             = w_pc;
  assign bus.if_valid       = r_fv;
  assign bus.if_pc          = r_if_pc;
  assign bus.if_instruction = r_fv ? bus.instruction : NOP_INSTRUCTION;
  assign bus.fetch_count    = r_fetch_count;

`ifdef RISCV_IF_EBREAK_HALT_EN
  assign bus.halted = (r_state == HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule
`default_nettype wire
